// File: rtl/shuffle_sequencer.sv
// Game-phase controller for the puzzle board.
// A Scramble press issues RandNum pseudo-random moves over a valid/ack
// handshake, then hands the board to the player and latches when the
// player's board reports solved. Every output is a register.
module shuffle_sequencer #(
    parameter int unsigned  RandNum   = 31,
    parameter logic [7:0]   LFSR_SEED = 8'hA5,
    localparam int unsigned MLW       = (RandNum < 1) ? 1 : $clog2(RandNum + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ScrambleButton,
    input  logic           move_ack,
    input  logic           puzzle_solved,
    output logic           move_valid,
    output logic [1:0]     move_dir,
    output logic [MLW-1:0] moves_left,
    output logic           mix_state,
    output logic           NoBuzz,
    output logic           solved
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHUFFLE = 2'd1,
        S_SOLVE   = 2'd2,
        S_SOLVED  = 2'd3
    } state_t;

    state_t         r_state;
    logic [7:0]     r_lfsr;
    logic           r_btn_q;
    logic           r_prev_valid;
    logic [1:0]     r_prev_dir;
    logic           r_solve_armed;
    logic           r_move_valid;
    logic [1:0]     r_move_dir;
    logic [MLW-1:0] r_moves_left;
    logic           r_mix_state;
    logic           r_no_buzz;
    logic           r_solved;

    state_t         w_state_nxt;
    logic           w_prev_valid_nxt;
    logic [1:0]     w_prev_dir_nxt;
    logic           w_solve_armed_nxt;
    logic           w_move_valid_nxt;
    logic [1:0]     w_move_dir_nxt;
    logic [MLW-1:0] w_moves_left_nxt;
    logic           w_solved_nxt;
    logic           w_mix_nxt;

    logic           w_press;
    logic           w_start;
    logic           w_lfsr_fb;
    logic [1:0]     w_candidate;
    logic [1:0]     w_dir_pick;

    // Rising edge of the (already debounced) button level.
    assign w_press     = ScrambleButton & ~r_btn_q;
    // A press starts a new scramble from any phase except an active shuffle.
    assign w_start     = w_press & (r_state != S_SHUFFLE);
    // Fibonacci feedback, taps 8,6,5,4 (1-based from the LSB).
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_candidate = r_lfsr[1:0];
    // Never undo the previous move: an opposite candidate is swapped onto the other axis.
    assign w_dir_pick  = (r_prev_valid && (w_candidate == (r_prev_dir ^ 2'b01)))
                         ? (w_candidate ^ 2'b10) : w_candidate;

    // Next-state and next-output logic for the phase FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no branch can infer a latch.
        w_state_nxt       = r_state;
        w_prev_valid_nxt  = r_prev_valid;
        w_prev_dir_nxt    = r_prev_dir;
        w_solve_armed_nxt = r_solve_armed;
        w_move_valid_nxt  = r_move_valid;
        w_move_dir_nxt    = r_move_dir;
        w_moves_left_nxt  = r_moves_left;
        w_solved_nxt      = r_solved;

        case (r_state)
            S_SHUFFLE: begin
                if (r_move_valid) begin
                    if (move_ack) begin
                        w_move_valid_nxt = 1'b0;
                        w_moves_left_nxt = r_moves_left - MLW'(1);
                        w_prev_dir_nxt   = r_move_dir;
                        w_prev_valid_nxt = 1'b1;
                        if (r_moves_left == MLW'(1)) begin
                            w_state_nxt       = S_SOLVE;
                            w_solve_armed_nxt = 1'b0;
                        end
                    end
                end else begin
                    // The idle cycle between moves: present the next one.
                    w_move_dir_nxt   = w_dir_pick;
                    w_move_valid_nxt = 1'b1;
                end
            end
            S_SOLVE: begin
                // The entry cycle only arms the solved detector.
                w_solve_armed_nxt = 1'b1;
                if (r_solve_armed && puzzle_solved) begin
                    w_state_nxt  = S_SOLVED;
                    w_solved_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // A press overrides whatever the current phase decided.
        if (w_start) begin
            w_solved_nxt      = 1'b0;
            w_move_valid_nxt  = 1'b0;
            w_prev_valid_nxt  = 1'b0;
            w_solve_armed_nxt = 1'b0;
            if (RandNum == 0) begin
                w_state_nxt      = S_SOLVE;
                w_moves_left_nxt = '0;
            end else begin
                w_state_nxt      = S_SHUFFLE;
                w_moves_left_nxt = MLW'(RandNum);
            end
        end

        w_mix_nxt = (w_state_nxt == S_SOLVE);
    end

    // State, LFSR, button history and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_lfsr        <= LFSR_SEED;
            r_btn_q       <= 1'b0;
            r_prev_valid  <= 1'b0;
            r_prev_dir    <= 2'd0;
            r_solve_armed <= 1'b0;
            r_move_valid  <= 1'b0;
            r_move_dir    <= 2'd0;
            r_moves_left  <= '0;
            r_mix_state   <= 1'b0;
            r_no_buzz     <= 1'b1;
            r_solved      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state       <= w_state_nxt;
            r_lfsr        <= {r_lfsr[6:0], w_lfsr_fb};
            r_btn_q       <= ScrambleButton;
            r_prev_valid  <= w_prev_valid_nxt;
            r_prev_dir    <= w_prev_dir_nxt;
            r_solve_armed <= w_solve_armed_nxt;
            r_move_valid  <= w_move_valid_nxt;
            r_move_dir    <= w_move_dir_nxt;
            r_moves_left  <= w_moves_left_nxt;
            r_mix_state   <= w_mix_nxt;
            r_no_buzz     <= ~w_mix_nxt;
            r_solved      <= w_solved_nxt;
        end
    end

    assign move_valid = r_move_valid;
    assign move_dir   = r_move_dir;
    assign moves_left = r_moves_left;
    assign mix_state  = r_mix_state;
    assign NoBuzz     = r_no_buzz;
    assign solved     = r_solved;

endmodule

// File: tb/tb_shuffle_sequencer.sv
// Bench for shuffle_sequencer: a phase-level model checked every cycle,
// a handshake log checked against the scramble rules, and literal checks
// for reset, the LFSR start, stalls, the solve phase and a RandNum=0 build.
`timescale 1ns/1ps
module tb_shuffle_sequencer;

    localparam int R        = 31;
    localparam int PH_IDLE  = 0;
    localparam int PH_MIX   = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_DONE  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RandNum = 31)
    logic       reset = 1'b1;
    logic       btn   = 1'b0;
    logic       ack   = 1'b0;
    logic       ps    = 1'b0;
    logic       mv;
    logic [1:0] md;
    logic [4:0] ml;
    logic       mix, nb, sol;

    // Zero-move instance
    logic       reset0 = 1'b1;
    logic       btn0   = 1'b0;
    logic       ack0   = 1'b0;
    logic       ps0    = 1'b0;
    logic       mv0;
    logic [1:0] md0;
    logic [0:0] ml0;
    logic       mix0, nb0, sol0;

    shuffle_sequencer #(.RandNum(R), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .reset(reset), .ScrambleButton(btn), .move_ack(ack),
        .puzzle_solved(ps), .move_valid(mv), .move_dir(md), .moves_left(ml),
        .mix_state(mix), .NoBuzz(nb), .solved(sol)
    );

    shuffle_sequencer #(.RandNum(0), .LFSR_SEED(8'hA5)) dut0 (
        .clk(clk), .reset(reset0), .ScrambleButton(btn0), .move_ack(ack0),
        .puzzle_solved(ps0), .move_valid(mv0), .move_dir(md0), .moves_left(ml0),
        .mix_state(mix0), .NoBuzz(nb0), .solved(sol0)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int         m_phase;
    bit         m_valid;
    logic [1:0] m_dir;
    int         m_left;
    bit         m_have_prev;
    logic [1:0] m_prev;
    int         m_age;
    bit         m_solved;
    bit         m_btn_prev;
    logic [7:0] m_lfsr;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_valid = 0; m_dir = 2'd0; m_left = 0;
        m_have_prev = 0; m_prev = 2'd0; m_age = 0; m_solved = 0;
        m_btn_prev = 0; m_lfsr = 8'hA5;
    endtask

    task automatic model_start();
        m_phase = PH_MIX; m_left = R; m_have_prev = 0; m_solved = 0; m_valid = 0;
    endtask

    task automatic model_step();
        bit         press;
        logic [1:0] cand;
        press      = btn && !m_btn_prev;
        m_btn_prev = btn;
        cand       = m_lfsr[1:0];
        m_lfsr     = lfsr_next(m_lfsr);
        case (m_phase)
            PH_MIX: begin
                if (m_valid) begin
                    if (ack) begin
                        m_valid = 0; m_left--; m_prev = m_dir; m_have_prev = 1;
                        if (m_left == 0) begin m_phase = PH_PLAY; m_age = 0; end
                    end
                end else begin
                    m_dir   = (m_have_prev && cand == (m_prev ^ 2'd1)) ? (cand ^ 2'd2) : cand;
                    m_valid = 1;
                end
            end
            PH_PLAY: begin
                if (press) model_start();
                else if (m_age >= 1 && ps) begin m_phase = PH_DONE; m_solved = 1; end
                m_age++;
            end
            default: if (press) model_start();
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("mix_state",  mix, m_phase == PH_PLAY);
            check("NoBuzz",     nb,  m_phase != PH_PLAY);
            check("move_valid", mv,  m_valid);
            check("moves_left", ml,  m_left);
            check("solved",     sol, m_solved);
            if (m_valid) check("move_dir", md, m_dir);
        end
    end

    // ---------------- ack responder ----------------
    int ack_mode  = 0;
    int ack_delay = 1;
    initial begin
        int vcnt;
        vcnt = 0;
        forever begin
            @(negedge clk); #1;
            if (reset || ack_mode == 0) begin ack = 0; vcnt = 0; end
            else if (ack)               begin ack = 0; vcnt = 0; end
            else if (mv) begin
                vcnt++;
                if (vcnt >= ack_delay) ack = 1;
            end else vcnt = 0;
        end
    end

    // ---------------- handshake log ----------------
    logic [1:0] hs_dir[$];
    int         hs_left[$];
    bit         hs_mix[$];
    initial begin
        bit pend;
        pend = 0;
        forever begin
            @(negedge clk); #3;
            if (pend) begin hs_mix.push_back(mix); pend = 0; end
            if (!reset && mv && ack) begin
                hs_dir.push_back(md);
                hs_left.push_back(ml);
                pend = 1;
            end
        end
    end

    task automatic check_shuffle_log(input int base);
        check("handshake_count", hs_dir.size() - base, R);
        if (hs_dir.size() - base == R) begin
            for (int i = 0; i < R; i++) begin
                check("moves_left_step", hs_left[base + i], R - i);
                if (i > 0) check("no_undo", (hs_dir[base + i] ^ hs_dir[base + i - 1]) == 2'b01, 0);
            end
            if (hs_mix.size() >= base + R) begin
                check("mix_before_last_ack", hs_mix[base + R - 2], 0);
                check("mix_after_last_ack",  hs_mix[base + R - 1], 1);
            end else check("mix_log_length", hs_mix.size(), base + R);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int         k;
        int         base;
        logic [1:0] rec_d;
        logic [4:0] rec_l;

        // Reset state
        @(negedge clk);
        check("rst_move_valid", mv, 0);
        check("rst_moves_left", ml, 0);
        check("rst_NoBuzz",     nb, 1);
        check("rst_mix_state",  mix, 0);
        reset = 0;
        repeat (100) @(negedge clk);
        check("idle_mix_state",  mix, 0);
        check("idle_NoBuzz",     nb,  1);
        check("idle_move_valid", mv,  0);
        check("idle_moves_left", ml,  0);
        check("idle_solved",     sol, 0);

        // Re-reset, release with the button already high: LFSR start pinned.
        #2 reset = 1;
        @(negedge clk);
        ack_delay = 1; ack_mode = 1;
        @(negedge clk);
        reset = 0; btn = 1;
        base = hs_dir.size();
        @(negedge clk);
        check("press_valid_low", mv, 0);
        check("press_moves_31",  ml, 31);
        @(negedge clk);
        check("first_valid",     mv, 1);
        check("first_dir_lit",   md, 2);
        @(negedge clk);
        check("after_ack_valid", mv, 0);
        check("after_ack_left",  ml, 30);
        @(negedge clk);
        check("second_valid",    mv, 1);
        check("second_dir_lit",  md, 2);
        ack_delay = 3;
        repeat (46) @(negedge clk);
        btn = 0;

        // Stall mid-shuffle with a press attempt.
        for (k = 0; k < 1000 && !(mv === 1'b1 && ml <= 5'd12); k++) @(negedge clk);
        check("wait_stall_point", k < 1000, 1);
        ack_mode = 0;
        rec_d = md; rec_l = ml;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            check("stall_valid", mv, 1);
            check("stall_dir",   md, rec_d);
            check("stall_left",  ml, rec_l);
            if (c == 50) btn = 1;
            if (c == 55) btn = 0;
        end
        ack_mode = 1;

        // Solve phase
        for (k = 0; k < 2000 && mix !== 1'b1; k++) @(negedge clk);
        check("wait_solve", k < 2000, 1);
        ps = 1;                       // entry cycle: must be ignored
        @(negedge clk);
        ps = 0;
        check("entry_ignored_solved", sol, 0);
        check("entry_ignored_mix",    mix, 1);
        @(negedge clk);
        ps = 1;
        @(negedge clk);
        ps = 0;
        check("solved_flag",   sol, 1);
        check("solved_NoBuzz", nb,  1);
        check("solved_mix",    mix, 0);
        check_shuffle_log(base);

        // New press restarts the scramble.
        btn = 1;
        @(negedge clk);
        check("restart_solved", sol, 0);
        check("restart_left",   ml,  31);
        check("restart_mix",    mix, 0);

        // Asynchronous reset in the middle of a shuffle.
        for (k = 0; k < 2000 && !(mv === 1'b1 && ml === 5'd17); k++) @(negedge clk);
        check("wait_left_17", k < 2000, 1);
        ack_mode = 0;
        #2 reset = 1;
        #1;
        check("async_valid",  mv,  0);
        check("async_dir",    md,  0);
        check("async_left",   ml,  0);
        check("async_mix",    mix, 0);
        check("async_NoBuzz", nb,  1);
        check("async_solved", sol, 0);
        repeat (2) @(negedge clk);
        reset = 0; btn = 0; ack_mode = 1;
        base = hs_dir.size();
        @(negedge clk);
        btn = 1;
        @(negedge clk);
        check("fresh_left", ml, 31);
        for (k = 0; k < 2000 && mix !== 1'b1; k++) @(negedge clk);
        check("wait_fresh_solve", k < 2000, 1);
        repeat (2) @(negedge clk);
        btn = 0;
        check_shuffle_log(base);

        // Zero-move build
        @(negedge clk);
        reset0 = 0;
        @(negedge clk);
        check("z_idle_mix",    mix0, 0);
        check("z_idle_NoBuzz", nb0,  1);
        btn0 = 1;
        @(negedge clk);
        check("z_solve_mix",    mix0, 1);
        check("z_solve_NoBuzz", nb0,  0);
        check("z_solve_left",   ml0,  0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("z_no_valid", mv0,  0);
            check("z_dir_zero", md0,  0);
            check("z_stay_mix", mix0, 1);
        end
        btn0 = 0;
        @(negedge clk);
        btn0 = 1; ps0 = 1;
        @(negedge clk);
        check("z_press_wins_solved", sol0, 0);
        check("z_press_wins_mix",    mix0, 1);
        @(negedge clk);
        check("z_reentry_ignored", sol0, 0);
        @(negedge clk);
        check("z_solved",     sol0, 1);
        check("z_solved_mix", mix0, 0);
        ps0 = 0; btn0 = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
